// File: rtl/mem_port_arbiter.sv
// Arbitrates the single DataMem port between instruction fetch (IF) and load/store (LS).
// LS has priority, a starvation counter forces IF through, and flush drops pending fetches.
module mem_port_arbiter #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int MaxWait   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 if_req_valid,
    input  logic [AddrWidth-1:0] if_req_addr,
    output logic                 if_req_ready,
    output logic                 if_rsp_valid,
    output logic [DataWidth-1:0] if_rsp_data,
    input  logic                 ls_req_valid,
    input  logic                 ls_req_write,
    input  logic [2:0]           ls_req_func3,
    input  logic [AddrWidth-1:0] ls_req_addr,
    input  logic [DataWidth-1:0] ls_req_wdata,
    output logic                 ls_req_ready,
    output logic                 ls_rsp_valid,
    output logic [DataWidth-1:0] ls_rsp_data,
    output logic                 mem_we,
    output logic [2:0]           mem_func3,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_wdata,
    input  logic [DataWidth-1:0] mem_rdata,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, ACC_IF, ACC_LS} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             wait_cnt_q, wait_cnt_d;
    logic [AddrWidth-1:0]   addr_q;
    logic [DataWidth-1:0]   wdata_q;
    logic [2:0]             func3_q;
    logic                   write_q;
    logic                   drop_q;
    logic                   if_rsp_valid_q, ls_rsp_valid_q;
    logic [DataWidth-1:0]   if_rsp_data_q, ls_rsp_data_q;
    logic                   if_grant, ls_grant, starved, if_fire;

    // Grants are gated by reset so both readies read 0 while the block is held in reset.
    always_comb begin
        starved  = (wait_cnt_q == 4'(MaxWait)) && if_req_valid;
        ls_grant = reset && ls_req_valid && !starved;
        if_grant = reset && if_req_valid && !ls_grant;
        if_fire  = (state_q == ACC_IF) && !flush && !drop_q;
    end

    always_comb begin
        // NOTE: assign a default first so every path drives the signal and no latch is inferred.
        wait_cnt_d = wait_cnt_q;
        if (!if_req_valid || if_grant) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != 4'(MaxWait)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        if (ls_grant) begin
            state_d = ACC_LS;
        end else if (if_grant) begin
            state_d = ACC_IF;
        end
    end

    always_comb begin
        if_req_ready = if_grant;
        ls_req_ready = ls_grant;
        busy         = (state_q != IDLE);
        mem_we       = 1'b0;
        mem_func3    = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if (state_q != IDLE) begin
            mem_we    = (state_q == ACC_LS) && write_q;
            mem_func3 = func3_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q     <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            func3_q        <= '0;
            write_q        <= 1'b0;
            drop_q         <= 1'b0;
            if_rsp_valid_q <= 1'b0;
            ls_rsp_valid_q <= 1'b0;
            if_rsp_data_q  <= '0;
            ls_rsp_data_q  <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            if (ls_grant) begin
                addr_q  <= ls_req_addr;
                wdata_q <= ls_req_wdata;
                func3_q <= ls_req_func3;
                write_q <= ls_req_write;
                drop_q  <= 1'b0;
            end else if (if_grant) begin
                addr_q  <= if_req_addr;
                wdata_q <= '0;
                func3_q <= 3'b010;
                write_q <= 1'b0;
                drop_q  <= flush;
            end
            if_rsp_valid_q <= if_fire;
            if_rsp_data_q  <= if_fire ? mem_rdata : '0;
            ls_rsp_valid_q <= (state_q == ACC_LS);
            ls_rsp_data_q  <= ((state_q == ACC_LS) && !write_q) ? mem_rdata : '0;
        end
    end

    assign if_rsp_valid = if_rsp_valid_q;
    assign if_rsp_data  = if_rsp_data_q;
    assign ls_rsp_valid = ls_rsp_valid_q;
    assign ls_rsp_data  = ls_rsp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a behavioural DataMem, a reference memory,
// and response queues filled at each handshake and drained as response pulses arrive.
module tb_mem_port_arbiter;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk, reset, flush;
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [31:0] if_req_addr, if_rsp_data;
    logic        ls_req_valid, ls_req_write, ls_req_ready, ls_rsp_valid;
    logic [2:0]  ls_req_func3, mem_func3;
    logic [31:0] ls_req_addr, ls_req_wdata, ls_rsp_data;
    logic        mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] tb_mem [256];
    logic        tb_written [256];
    logic [31:0] ref_mem [256];
    logic        ref_written [256];

    exp_t        if_q[$];
    exp_t        ls_q[$];
    int          n_tests, n_fail, cyc;
    int          we_cnt, if_rsp_cnt, ls_rsp_cnt;
    logic [31:0] last_if_data, last_ls_data;

    mem_port_arbiter #(.AddrWidth(32), .DataWidth(32), .MaxWait(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_write(ls_req_write), .ls_req_func3(ls_req_func3),
        .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata), .ls_req_ready(ls_req_ready),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .mem_we(mem_we), .mem_func3(mem_func3), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(logic [7:0] i);
        return {8'hA5, i, ~i, i};
    endfunction

    always_comb begin
        mem_rdata = tb_written[mem_addr[9:2]] === 1'b1 ? tb_mem[mem_addr[9:2]]
                                                      : init_word(mem_addr[9:2]);
    end

    always @(posedge clk) begin
        if (mem_we) begin
            tb_mem[mem_addr[9:2]]     <= mem_wdata;
            tb_written[mem_addr[9:2]] <= 1'b1;
        end
    end

    function automatic logic [31:0] ref_read(logic [31:0] a);
        return ref_written[a[9:2]] === 1'b1 ? ref_mem[a[9:2]] : init_word(a[9:2]);
    endfunction

    task automatic idle_inputs();
        flush = 0; if_req_valid = 0; if_req_addr = '0;
        ls_req_valid = 0; ls_req_write = 0; ls_req_func3 = 3'b010;
        ls_req_addr = '0; ls_req_wdata = '0;
    endtask

    // One clock: score responses and handshakes at the falling edge, return at posedge + 1.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (if_rsp_valid) begin
            if_rsp_cnt++; last_if_data = if_rsp_data; n_tests++;
            if (if_q.size() == 0) begin
                n_fail++; $display("FAIL if_rsp_unexpected cyc=%0d data=%h required none", cyc, if_rsp_data);
            end else begin
                e = if_q.pop_front();
                if (if_rsp_data !== e.data || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL if_rsp data=%h cyc=%0d required data=%h cyc=%0d", if_rsp_data, cyc, e.data, e.due);
                end
            end
        end
        if (ls_rsp_valid) begin
            ls_rsp_cnt++; last_ls_data = ls_rsp_data; n_tests++;
            if (ls_q.size() == 0) begin
                n_fail++; $display("FAIL ls_rsp_unexpected cyc=%0d data=%h required none", cyc, ls_rsp_data);
            end else begin
                e = ls_q.pop_front();
                if (ls_rsp_data !== e.data || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL ls_rsp data=%h cyc=%0d required data=%h cyc=%0d", ls_rsp_data, cyc, e.data, e.due);
                end
            end
        end
        while (if_q.size() > 0 && if_q[0].due < cyc) begin
            e = if_q.pop_front(); n_tests++; n_fail++;
            $display("FAIL if_rsp_missing cyc=%0d required data=%h at cyc=%0d", cyc, e.data, e.due);
        end
        while (ls_q.size() > 0 && ls_q[0].due < cyc) begin
            e = ls_q.pop_front(); n_tests++; n_fail++;
            $display("FAIL ls_rsp_missing cyc=%0d required data=%h at cyc=%0d", cyc, e.data, e.due);
        end
        if (if_req_valid && if_req_ready) if_q.push_back('{ref_read(if_req_addr), cyc + 2});
        if (ls_req_valid && ls_req_ready) begin
            ls_q.push_back('{ls_req_write ? 32'h0 : ref_read(ls_req_addr), cyc + 2});
            if (ls_req_write) begin
                ref_mem[ls_req_addr[9:2]]     = ls_req_wdata;
                ref_written[ls_req_addr[9:2]] = 1'b1;
            end
        end
        if (flush) begin
            while (if_q.size() > 0 && if_q[$].due >= cyc + 1) if_q.pop_back();
        end
        if (mem_we) we_cnt++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && (if_q.size() > 0 || ls_q.size() > 0); i++) cycle();
        n_tests++;
        if (if_q.size() != 0 || ls_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending if=%0d ls=%0d required 0 0", if_q.size(), ls_q.size());
        end
        cycle();
    endtask

    task automatic test_reset();
        int n0;
        reset = 0; idle_inputs();
        if_req_valid = 1; ls_req_valid = 1; ls_req_write = 1; ls_req_wdata = 32'hFFFF_FFFF;
        repeat (3) begin
            @(posedge clk); #1;
            n_tests++;
            if ({if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, mem_we, busy,
                 mem_func3, mem_addr, mem_wdata, if_rsp_data, ls_rsp_data} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs busy=%b mem_we=%b mem_addr=%h required all 0", busy, mem_we, mem_addr);
            end
        end
        reset = 1; idle_inputs(); if_req_valid = 1; if_req_addr = 32'h0;
        #1;
        n_tests++;
        if (if_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL first_if_ready got=%b required 1", if_req_ready);
        end
        n0 = if_rsp_cnt;
        cycle();
        idle_inputs(); #1;
        n_tests++;
        if (mem_addr !== 32'h0 || busy !== 1'b1 || mem_func3 !== 3'b010 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL first_if_mem addr=%h busy=%b func3=%b we=%b required 0 1 010 0", mem_addr, busy, mem_func3, mem_we);
        end
        drain();
        n_tests++;
        if (if_rsp_cnt != n0 + 1 || last_if_data !== init_word(8'd0)) begin
            n_fail++;
            $display("FAIL first_if_rsp count=%0d data=%h required %0d %h", if_rsp_cnt - n0, last_if_data, 1, init_word(8'd0));
        end
    endtask

    task automatic test_store_load();
        int n0;
        we_cnt = 0; n0 = ls_rsp_cnt;
        ls_req_valid = 1; ls_req_write = 1; ls_req_addr = 32'h40; ls_req_wdata = 32'hDEAD_BEEF;
        cycle();
        ls_req_write = 0; ls_req_wdata = '0;
        cycle();
        idle_inputs();
        drain();
        n_tests++;
        if (we_cnt != 1) begin
            n_fail++; $display("FAIL store_we_cycles got=%0d required 1", we_cnt);
        end
        n_tests++;
        if (ls_rsp_cnt != n0 + 2 || last_ls_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL store_load_rsp count=%0d data=%h required 2 deadbeef", ls_rsp_cnt - n0, last_ls_data);
        end
    endtask

    task automatic test_starvation();
        int exp_wait, if_wins;
        logic exp_ls;
        exp_wait = 0; if_wins = 0;
        if_req_valid = 1; if_req_addr = 32'h100;
        ls_req_valid = 1; ls_req_write = 0; ls_req_addr = 32'h200;
        for (int i = 0; i < 15; i++) begin
            #1;
            exp_ls = (exp_wait != 4);
            n_tests++;
            if (ls_req_ready !== exp_ls || if_req_ready !== !exp_ls) begin
                n_fail++;
                $display("FAIL starve_grant i=%0d ls=%b if=%b required ls=%b if=%b", i, ls_req_ready, if_req_ready, exp_ls, !exp_ls);
            end
            n_tests++;
            if (dut.wait_cnt_q > 4) begin
                n_fail++; $display("FAIL starve_wait_cnt i=%0d got=%0d required <=4", i, dut.wait_cnt_q);
            end
            cycle();
            if (exp_ls) begin
                exp_wait++; ls_req_addr = ls_req_addr + 32'h4;
            end else begin
                exp_wait = 0; if_wins++; if_req_addr = if_req_addr + 32'h4;
            end
        end
        idle_inputs();
        drain();
        n_tests++;
        if (if_wins != 3) begin
            n_fail++; $display("FAIL starve_if_wins got=%0d required 3", if_wins);
        end
    endtask

    task automatic test_flush();
        int n0;
        n0 = if_rsp_cnt;
        if_req_valid = 1; if_req_addr = 32'h10;
        cycle();
        if_req_valid = 0; flush = 1;
        cycle();
        flush = 0; if_req_valid = 1; if_req_addr = 32'h20;
        cycle();
        idle_inputs();
        drain();
        n_tests++;
        if (if_rsp_cnt != n0 + 1 || last_if_data !== init_word(8'd8)) begin
            n_fail++;
            $display("FAIL flush_inflight count=%0d data=%h required 1 %h", if_rsp_cnt - n0, last_if_data, init_word(8'd8));
        end
        n0 = if_rsp_cnt;
        if_req_valid = 1; if_req_addr = 32'h30; flush = 1;
        cycle();
        idle_inputs();
        repeat (3) cycle();
        n_tests++;
        if (if_rsp_cnt != n0) begin
            n_fail++; $display("FAIL flush_same_cycle count=%0d required 0", if_rsp_cnt - n0);
        end
    endtask

    task automatic test_reset_store();
        int n0;
        n0 = ls_rsp_cnt;
        ls_req_valid = 1; ls_req_write = 1; ls_req_addr = 32'h80; ls_req_wdata = 32'h1234_5678;
        cycle();
        idle_inputs();
        n_tests++;
        if (mem_we !== 1'b1) begin
            n_fail++; $display("FAIL abort_store_we_before got=%b required 1", mem_we);
        end
        #2 reset = 0;
        #1;
        n_tests++;
        if (mem_we !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_store_async we=%b busy=%b required 0 0", mem_we, busy);
        end
        if_q.delete(); ls_q.delete();
        ref_written[32] = 1'b0;
        repeat (2) cycle();
        reset = 1;
        repeat (2) cycle();
        n_tests++;
        if (ls_rsp_cnt != n0 || tb_written[32] === 1'b1) begin
            n_fail++;
            $display("FAIL abort_store_effect rsp=%0d written=%b required 0 0", ls_rsp_cnt - n0, tb_written[32]);
        end
        ls_req_valid = 1; ls_req_addr = 32'h80;
        cycle();
        idle_inputs();
        drain();
    endtask

    task automatic test_idle();
        int n_if, n_ls;
        n_if = if_rsp_cnt; n_ls = ls_rsp_cnt;
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (busy !== 1'b0 || mem_we !== 1'b0 || if_rsp_valid !== 1'b0 || ls_rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle i=%0d busy=%b we=%b ifr=%b lsr=%b required 0 0 0 0", i, busy, mem_we, if_rsp_valid, ls_rsp_valid);
            end
            cycle();
        end
        n_tests++;
        if (if_rsp_cnt != n_if || ls_rsp_cnt != n_ls) begin
            n_fail++; $display("FAIL idle_pulses if=%0d ls=%0d required 0 0", if_rsp_cnt - n_if, ls_rsp_cnt - n_ls);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        we_cnt = 0; if_rsp_cnt = 0; ls_rsp_cnt = 0;
        last_if_data = '0; last_ls_data = '0;
        for (int i = 0; i < 256; i++) ref_written[i] = 1'b0;
        test_reset();
        test_store_load();
        test_starvation();
        test_flush();
        test_reset_store();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
